// File: rtl/enc_pkg.sv
// Shared definitions for the file-encryption path: mode encodings,
// character limits and the FSM state type used by encryption/decryption.
package enc_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_IDLE = 2'b00;
  localparam logic [MODE_W-1:0] MODE_KEY  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_DEC  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_RSVD = 2'b11;

  localparam logic [CHAR_W-1:0] NUL_CHAR      = 8'h00;
  localparam logic [CHAR_W-1:0] PRINT_MIN_DEF = 8'h20;
  localparam logic [CHAR_W-1:0] PRINT_MAX_DEF = 8'h7E;

  typedef enum logic [1:0] {
    S_NOKEY = 2'd0,
    S_READY = 2'd1,
    S_CALC  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  function automatic logic in_range(input logic [CHAR_W-1:0] c,
                                    input logic [CHAR_W-1:0] lo,
                                    input logic [CHAR_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/key_stream.sv
// Running key generator: holds the loaded key and a character index,
// presents K_i = key + idx (mod 256); shared with the encryption side.
module key_stream
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CHAR_W-1:0] load_key,
  input  logic              advance,
  output logic [CHAR_W-1:0] k_i_c
);

  logic [CHAR_W-1:0] key_reg;
  logic [CHAR_W-1:0] idx;

  // A load always restarts the index so both ends stay in step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
      idx     <= '0;
    end else if (load) begin
      key_reg <= load_key;
      idx     <= '0;
    end else if (advance) begin
      idx     <= idx + CHAR_W'(1);
    end
  end

  assign k_i_c = key_reg + idx;

endmodule

// File: rtl/decryption.sv
// Character-serial decryptor: P = C - K_i (mod 256), flags non-printable
// results and keeps the key index in step only on accepted characters.
module decryption
  import enc_pkg::*;
#(
  parameter logic [CHAR_W-1:0] PRINT_MIN = PRINT_MIN_DEF,
  parameter logic [CHAR_W-1:0] PRINT_MAX = PRINT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic [CHAR_W-1:0] Ciphertext,
  input  logic [CHAR_W-1:0] Private_key,
  output logic [CHAR_W-1:0] Char_plaintext,
  output logic              P_ready,
  output logic              err_invalid_ctxt,
  output logic              err_invalid_key
);

  state_t            state_q, state_d;
  logic [CHAR_W-1:0] c_q, c_d;
  logic [CHAR_W-1:0] k_q, k_d;
  logic [CHAR_W-1:0] char_d;
  logic              p_ready_d;
  logic              err_ctxt_d;
  logic              err_key_d;
  logic              load_c;
  logic              advance_c;
  logic [CHAR_W-1:0] k_i_c;
  logic [CHAR_W-1:0] p_c;

  key_stream u_key_stream (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_key (Private_key),
    .advance  (advance_c),
    .k_i_c    (k_i_c)
  );

  assign p_c = c_q - k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_NOKEY;
    else        state_q <= state_d;
  end

  // Next state and next output values; mode only matters in S_NOKEY/S_READY.
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    k_d        = k_q;
    char_d     = Char_plaintext;
    p_ready_d  = 1'b0;
    err_ctxt_d = err_invalid_ctxt;
    err_key_d  = err_invalid_key;
    load_c     = 1'b0;
    advance_c  = 1'b0;
    case (state_q)
      S_NOKEY, S_READY: begin
        if (mode == MODE_KEY) begin
          load_c = 1'b1;
          if (Private_key == NUL_CHAR) begin
            err_key_d = 1'b1;
            state_d   = S_NOKEY;
          end else begin
            err_key_d = 1'b0;
            state_d   = S_READY;
          end
        end else if ((mode == MODE_DEC) && (state_q == S_READY)) begin
          c_d     = Ciphertext;
          k_d     = k_i_c;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        p_ready_d = 1'b1;
        state_d   = S_OUT;
        if (in_range(p_c, PRINT_MIN, PRINT_MAX)) begin
          char_d     = p_c;
          err_ctxt_d = 1'b0;
          advance_c  = 1'b1;
        end else begin
          char_d     = NUL_CHAR;
          err_ctxt_d = 1'b1;
        end
      end
      S_OUT: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_NOKEY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q              <= '0;
      k_q              <= '0;
      Char_plaintext   <= NUL_CHAR;
      P_ready          <= 1'b0;
      err_invalid_ctxt <= 1'b0;
      err_invalid_key  <= 1'b0;
    end else begin
      c_q              <= c_d;
      k_q              <= k_d;
      Char_plaintext   <= char_d;
      P_ready          <= p_ready_d;
      err_invalid_ctxt <= err_ctxt_d;
      err_invalid_key  <= err_key_d;
    end
  end

endmodule

// File: tb/tb_decryption.sv
// Bench for decryption: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed plaintext.
module tb_decryption;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] ciphertext = 8'h00;
  logic [7:0] private_key = 8'h00;
  logic [7:0] char_plaintext;
  logic       p_ready;
  logic       err_invalid_ctxt;
  logic       err_invalid_key;

  int n_checks = 0;
  int n_errors = 0;

  decryption dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mode             (mode),
    .Ciphertext       (ciphertext),
    .Private_key      (private_key),
    .Char_plaintext   (char_plaintext),
    .P_ready          (p_ready),
    .err_invalid_ctxt (err_invalid_ctxt),
    .err_invalid_key  (err_invalid_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: key valid/value, index, and a pending result that
  // appears one edge after acceptance, followed by one dead edge.
  logic       m_key_ok, m_err_key, m_pready, m_err, m_due, m_cool;
  logic [7:0] m_key, m_idx, m_char, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_key_ok <= 1'b0; m_err_key <= 1'b0; m_pready <= 1'b0; m_err <= 1'b0;
      m_due <= 1'b0; m_cool <= 1'b0; m_key <= 8'h00; m_idx <= 8'h00;
      m_char <= 8'h00; m_res <= 8'h00;
    end else if (m_due) begin
      m_due <= 1'b0; m_cool <= 1'b1; m_pready <= 1'b1;
      if (m_res >= 8'h20 && m_res <= 8'h7E) begin
        m_char <= m_res; m_err <= 1'b0; m_idx <= m_idx + 8'd1;
      end else begin
        m_char <= 8'h00; m_err <= 1'b1;
      end
    end else if (m_cool) begin
      m_cool <= 1'b0; m_pready <= 1'b0;
    end else begin
      m_pready <= 1'b0;
      if (mode == 2'b01) begin
        m_key <= private_key; m_idx <= 8'h00;
        m_key_ok <= (private_key != 8'h00); m_err_key <= (private_key == 8'h00);
      end else if (mode == 2'b10 && m_key_ok) begin
        m_res <= ciphertext - (m_key + m_idx);
        m_due <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_p_ready", {7'd0, p_ready}, {7'd0, m_pready});
    check("model_char", char_plaintext, m_char);
    check("model_err_ctxt", {7'd0, err_invalid_ctxt}, {7'd0, m_err});
    check("model_err_key", {7'd0, err_invalid_key}, {7'd0, m_err_key});
  end

  task automatic load_key(input logic [7:0] k, input logic exp_err);
    @(negedge clk); mode = 2'b01; private_key = k;
    @(negedge clk); mode = 2'b00;
    check("key_flag", {7'd0, err_invalid_key}, {7'd0, exp_err});
  endtask

  task automatic decrypt(input logic [7:0] c, input logic [7:0] exp_p, input logic exp_err);
    @(negedge clk); mode = 2'b10; ciphertext = c;
    @(negedge clk); mode = 2'b00;
    check("pready_t1", {7'd0, p_ready}, 8'd0);
    @(negedge clk);
    check("pready_t2", {7'd0, p_ready}, 8'd1);
    check("plaintext", char_plaintext, exp_p);
    check("err_ctxt", {7'd0, err_invalid_ctxt}, {7'd0, exp_err});
    @(negedge clk);
    check("pready_t3", {7'd0, p_ready}, 8'd0);
  endtask

  task automatic idle_dec(input int n, output int pulses);
    pulses = 0;
    @(negedge clk); mode = 2'b10; ciphertext = 8'h61;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pulses += int'(p_ready);
    end
    mode = 2'b00;
  endtask

  initial begin
    int pulses;
    logic [7:0] c;
    repeat (2) @(negedge clk);
    check("rst_char", char_plaintext, 8'h00);
    check("rst_pready", {7'd0, p_ready}, 8'd0);
    check("rst_err_key", {7'd0, err_invalid_key}, 8'd0);
    rst_n = 1'b1;

    // Basic stream with key C8, including a non-printable result.
    load_key(8'hC8, 1'b0);
    decrypt(8'h29, 8'h61, 1'b0);
    decrypt(8'h2B, 8'h62, 1'b0);
    decrypt(8'hCA, 8'h00, 1'b1);
    decrypt(8'h2D, 8'h63, 1'b0);

    // Zero key blocks decryption until a good key arrives.
    load_key(8'h00, 1'b1);
    idle_dec(5, pulses);
    check("nokey_pulses", 8'(pulses), 8'd0);
    load_key(8'h05, 1'b0);
    decrypt(8'h4D, 8'h48, 1'b0);

    // 256 characters then index wrap back to K_0.
    load_key(8'h01, 1'b0);
    for (int i = 0; i < 256; i++) begin
      c = 8'h42 + 8'(i);
      decrypt(c, 8'h41, 1'b0);
    end
    decrypt(8'h42, 8'h41, 1'b0);

    // Range boundaries (idx=1, K=2 on entry).
    decrypt(8'h81, 8'h00, 1'b1);
    decrypt(8'h80, 8'h7E, 1'b0);
    decrypt(8'h23, 8'h20, 1'b0);
    decrypt(8'h23, 8'h00, 1'b1);

    // Continuous mode=10: one accept every third edge.
    load_key(8'h10, 1'b0);
    idle_dec(12, pulses);
    check("cont_pulses", 8'(pulses), 8'd4);

    // Key load during S_CALC must be ignored (key 10, idx 4 here).
    @(negedge clk); mode = 2'b10; ciphertext = 8'h55;
    @(negedge clk); mode = 2'b01; private_key = 8'h77;
    @(negedge clk); mode = 2'b00;
    check("calc_key_pready", {7'd0, p_ready}, 8'd1);
    check("calc_key_char", char_plaintext, 8'h41);
    decrypt(8'h57, 8'h42, 1'b0);

    // Asynchronous reset while in S_CALC.
    @(negedge clk); mode = 2'b10; ciphertext = 8'h56;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_char", char_plaintext, 8'h00);
    check("arst_pready", {7'd0, p_ready}, 8'd0);
    check("arst_err", {7'd0, err_invalid_ctxt}, 8'd0);
    mode = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    idle_dec(5, pulses);
    check("post_rst_pulses", 8'(pulses), 8'd0);
    load_key(8'h20, 1'b0);
    decrypt(8'h61, 8'h41, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
